// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between the command source/result consumer
// (master) and the ALU command sequencer (slave).
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_in1;
  logic [3:0] cmd_in2;
  logic [1:0] cmd_opcode;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_opcode;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_in1, cmd_in2, cmd_opcode, res_ready,
    input  cmd_ready, res_valid, res_data, res_opcode, res_err
  );

  modport slave (
    input  cmd_valid, cmd_in1, cmd_in2, cmd_opcode, res_ready,
    output cmd_ready, res_valid, res_data, res_opcode, res_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO in front of a combinational 4-bit ALU, with a registered result
// stage that flags divide-by-zero and keeps a saturating error count.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_cmd_sequencer_if.slave       bus,
  output logic [3:0]               dev_in1,
  output logic [3:0]               dev_in2,
  output logic [1:0]               dev_opcode,
  input  logic [7:0]               dev_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          cmd_ready_r;
  state_t        state_r;
  state_t        state_next_s;
  logic          push_s;
  logic          pop_s;
  logic          not_empty_s;
  logic [9:0]    head_s;
  logic          div_zero_s;
  logic [7:0]    res_data_r;
  logic [1:0]    res_opcode_r;
  logic          res_err_r;
  logic [7:0]    err_count_r;

  assign not_empty_s = (count_r != {CW{1'b0}});
  assign push_s      = bus.cmd_valid && cmd_ready_r;
  assign head_s      = mem_r[rd_ptr_r];
  assign div_zero_s  = (head_s[1:0] == 2'b11) && (head_s[5:2] == 4'b0000);

  // Occupancy after this edge's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Command storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.cmd_in1, bus.cmd_in2, bus.cmd_opcode};
    end
  end

  // Pointers, occupancy and ready; ready mirrors registered occupancy only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      cmd_ready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r     <= count_next_s;
      cmd_ready_r <= (count_next_s < DEPTH_C);
    end
  end

  // Result stage state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Result stage next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (not_empty_s) state_next_s = ST_FULL;
        else             state_next_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (bus.res_ready && !not_empty_s) state_next_s = ST_EMPTY;
        else                               state_next_s = ST_FULL;
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Result stage outputs: pop whenever the holding register is free or being drained
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_EMPTY: pop_s = not_empty_s;
      ST_FULL:  pop_s = not_empty_s && bus.res_ready;
      default:  pop_s = 1'b0;
    endcase
  end

  // Device drive: FIFO head while occupied, zero otherwise
  always_comb begin
    if (not_empty_s) begin
      dev_in1    = head_s[9:6];
      dev_in2    = head_s[5:2];
      dev_opcode = head_s[1:0];
    end else begin
      dev_in1    = 4'b0000;
      dev_in2    = 4'b0000;
      dev_opcode = 2'b00;
    end
  end

  // Result capture with divide-by-zero override and saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_r   <= 8'h00;
      res_opcode_r <= 2'b00;
      res_err_r    <= 1'b0;
      err_count_r  <= 8'h00;
    end else if (pop_s) begin
      res_opcode_r <= head_s[1:0];
      if (div_zero_s) begin
        res_data_r <= 8'hFF;
        res_err_r  <= 1'b1;
        if (err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
      end else begin
        res_data_r <= dev_out;
        res_err_r  <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.res_valid  = (state_r == ST_FULL);
  assign bus.res_data   = res_data_r;
  assign bus.res_opcode = res_opcode_r;
  assign bus.res_err    = res_err_r;
  assign count          = count_r;
  assign err_count      = err_count_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed self-checking bench for alu_cmd_sequencer, with a
// behavioural ALU device and a queue-based transaction reference model.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dev_in1;
  logic [3:0] dev_in2;
  logic [1:0] dev_opcode;
  logic [7:0] dev_out;
  logic [2:0] count;
  logic [7:0] err_count;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .dev_in1    (dev_in1),
    .dev_in2    (dev_in2),
    .dev_opcode (dev_opcode),
    .dev_out    (dev_out),
    .count      (count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    case (op)
      2'b00:   return {4'h0, a} + {4'h0, b};
      2'b01:   return {4'h0, a} - {4'h0, b};
      2'b10:   return {4'h0, a} * {4'h0, b};
      default: return (b == 4'h0) ? 8'h00 : ({4'h0, a} / {4'h0, b});
    endcase
  endfunction

  always_comb dev_out = alu_f(dev_in1, dev_in2, dev_opcode);

  int n_checks = 0;
  int n_errors = 0;

  cmd_t       m_q[$];
  bit         m_held = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [1:0] m_op = 2'b00;
  bit         m_err = 1'b0;
  int         m_errcnt = 0;
  bit         m_pushed = 1'b0;
  logic [7:0] consumed[$];
  logic [7:0] exp_list[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    cmd_t h;
    check("count", 32'(count), 32'(m_q.size()));
    check("cmd_ready", 32'(bus.cmd_ready), 32'(m_q.size() < DEPTH));
    check("res_valid", 32'(bus.res_valid), 32'(m_held));
    check("err_count", 32'(err_count), 32'(m_errcnt));
    if (m_held) begin
      check("res_data", 32'(bus.res_data), 32'(m_data));
      check("res_opcode", 32'(bus.res_opcode), 32'(m_op));
      check("res_err", 32'(bus.res_err), 32'(m_err));
    end
    h = (m_q.size() > 0) ? m_q[0] : cmd_t'(10'b0);
    check("dev", 32'({dev_in1, dev_in2, dev_opcode}), 32'(h));
  endtask

  // One clock: model decides push/pop from pre-edge state, then both advance and compare
  task automatic step();
    bit   do_pop;
    bit   do_push;
    bit   rr;
    cmd_t c;
    cmd_t h;
    rr = bus.res_ready;
    if (bus.res_valid && rr) consumed.push_back(bus.res_data);
    do_pop  = (m_q.size() > 0) && (!m_held || rr);
    do_push = bus.cmd_valid && (m_q.size() < DEPTH);
    c = {bus.cmd_in1, bus.cmd_in2, bus.cmd_opcode};
    @(posedge clk);
    #1;
    if (do_pop) begin
      h = m_q.pop_front();
      m_held = 1'b1;
      m_op = h.op;
      if (h.op == 2'b11 && h.b == 4'h0) begin
        m_data = 8'hFF;
        m_err = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end else begin
        m_data = alu_f(h.a, h.b, h.op);
        m_err = 1'b0;
      end
    end else if (m_held && rr) begin
      m_held = 1'b0;
    end
    if (do_push) m_q.push_back(c);
    m_pushed = do_push;
    compare_all();
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bit done;
    done = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_in1 = a;
    bus.cmd_in2 = b;
    bus.cmd_opcode = op;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = m_pushed;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_held = 1'b0;
    m_errcnt = 0;
  endtask

  task automatic check_consumed(input string tag);
    check({tag, "_n"}, 32'(consumed.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < consumed.size(); i++) begin
      check(tag, 32'(consumed[i]), 32'(exp_list[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_in1 = 4'h0;
    bus.cmd_in2 = 4'h0;
    bus.cmd_opcode = 2'b00;
    bus.res_ready = 1'b0;
    #12;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_err", 32'(bus.res_err), 32'd0);
    check("rst_res_opcode", 32'(bus.res_opcode), 32'd0);
    check("rst_dev", 32'({dev_in1, dev_in2, dev_opcode}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operations
    bus.res_ready = 1'b1;
    send(4'd2, 4'd3, 2'b10);
    step();
    check("mul_data", 32'(bus.res_data), 32'd6);
    check("mul_op", 32'(bus.res_opcode), 32'd2);
    check("mul_err", 32'(bus.res_err), 32'd0);
    check("mul_count", 32'(count), 32'd0);
    step();
    send(4'd6, 4'd3, 2'b11);
    step();
    check("div_data", 32'(bus.res_data), 32'd2);
    check("div_err", 32'(bus.res_err), 32'd0);
    step();
    send(4'd15, 4'd4, 2'b11);
    step();
    check("div_trunc", 32'(bus.res_data), 32'd3);
    step();
    send(4'd5, 4'd0, 2'b11);
    step();
    check("dz_data", 32'(bus.res_data), 32'hFF);
    check("dz_err", 32'(bus.res_err), 32'd1);
    check("dz_cnt", 32'(err_count), 32'd1);
    step();
    send(4'd9, 4'd9, 2'b10);
    step();
    check("mul81_data", 32'(bus.res_data), 32'd81);
    check("mul81_err", 32'(bus.res_err), 32'd0);
    check("mul81_cnt", 32'(err_count), 32'd1);
    step();

    // Backpressure fills the FIFO, then drains in order
    bus.res_ready = 1'b0;
    consumed.delete();
    send(4'd1, 4'd1, 2'b00);
    send(4'd7, 4'd2, 2'b01);
    send(4'd3, 4'd5, 2'b10);
    send(4'd8, 4'd2, 2'b11);
    send(4'd4, 4'd4, 2'b10);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_in1 = 4'd6;
    bus.cmd_in2 = 4'd3;
    bus.cmd_opcode = 2'b11;
    repeat (3) step();
    check("stall_count", 32'(count), 32'd4);
    bus.res_ready = 1'b1;
    step();
    check("ready_rise", 32'(bus.cmd_ready), 32'd1);
    check("ready_rise_cnt", 32'(count), 32'd3);
    step();
    check("late_push", 32'(m_pushed), 32'd1);
    bus.cmd_valid = 1'b0;
    repeat (8) step();
    exp_list = '{8'd2, 8'd5, 8'd15, 8'd4, 8'd16, 8'd2};
    check_consumed("bp_order");

    // Back-to-back throughput
    consumed.delete();
    exp_list.delete();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_in1 = 4'($urandom_range(0, 15));
      bus.cmd_in2 = 4'($urandom_range(1, 15));
      bus.cmd_opcode = 2'($urandom_range(0, 3));
      exp_list.push_back(alu_f(bus.cmd_in1, bus.cmd_in2, bus.cmd_opcode));
      step();
      check("b2b_cnt_le1", 32'(count <= 3'd1), 32'd1);
      if (i > 0) check("b2b_valid", 32'(bus.res_valid), 32'd1);
    end
    bus.cmd_valid = 1'b0;
    step();
    check("b2b_valid_last", 32'(bus.res_valid), 32'd1);
    repeat (2) step();
    check_consumed("b2b_order");

    // Asynchronous reset mid-operation
    bus.res_ready = 1'b0;
    repeat (4) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.res_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_errcnt", 32'(err_count), 32'd0);
    check("arst_ready", 32'(bus.cmd_ready), 32'd1);
    check("arst_dev", 32'({dev_in1, dev_in2, dev_opcode}), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    send(4'd2, 4'd3, 2'b10);
    step();
    check("post_rst_data", 32'(bus.res_data), 32'd6);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = ($urandom_range(0, 99) < 70);
      bus.cmd_in1 = 4'($urandom_range(0, 15));
      bus.cmd_in2 = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bus.cmd_opcode = 2'($urandom_range(0, 3));
      bus.res_ready = ($urandom_range(0, 99) < 60);
      step();
    end

    // Error counter saturation
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_in1 = 4'd7;
    bus.cmd_in2 = 4'd0;
    bus.cmd_opcode = 2'b11;
    repeat (270) step();
    bus.cmd_valid = 1'b0;
    repeat (4) step();
    check("err_saturate", 32'(err_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
